// File: rtl/rom_ctrl_kmac_resp.sv
// rom_ctrl_kmac_resp
// -----------------------------------------------------------------------------
// Responder side of the ROM-to-KMAC message stream. Words are accepted on a
// vld/rdy handshake and folded into TopCount 64-bit lanes, round-robin:
// lane = rotl1(lane) ^ word. When the last word is taken, the block waits
// DigestLatency cycles and then pulses done_o with the lane contents on
// digest_o. Protocol errors (message overflow or a retracted rom_vld_i) end
// the message early: done_o pulses with err_o=1 and the digest is cleared.
// The Done state is terminal until reset.
//
// Parameters:
//   TopCount      number of 64-bit digest lanes
//   MaxWords      maximum words in one message, including the last word
//   DigestLatency cycles from the last-word handshake to done_o (1..255)
//
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   rom_vld_i   initiator has a valid word
//   rom_last_i  current word is the final message word (used on handshake)
//   rom_data_i  64-bit message word
//   rom_rdy_o   responder accepts a word this cycle
//   done_o      one-cycle pulse: digest (or error) available
//   digest_o    lane registers, lane 0 in bits [63:0]
//   err_o       protocol error, qualified by done_o
//
// Build option:
//   ROM_CTRL_KMAC_RESP_STALL_EN  when defined, rom_rdy_o drops for one cycle
//                                after every handshake.
// -----------------------------------------------------------------------------
module rom_ctrl_kmac_resp #(
    parameter int TopCount      = 8,
    parameter int MaxWords      = 16,
    parameter int DigestLatency = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     rom_vld_i,
    input  logic                     rom_last_i,
    input  logic [63:0]              rom_data_i,
    output logic                     rom_rdy_o,
    output logic                     done_o,
    output logic [TopCount*64-1:0]   digest_o,
    output logic                     err_o
);

    // Counter must hold 0..MaxWords (a full message ending on its last word).
    localparam int CntW = (MaxWords + 1 > 2) ? $clog2(MaxWords + 1) : 1;

    typedef enum logic [1:0] {
        StAbsorb  = 2'b00,
        StSqueeze = 2'b01,
        StDone    = 2'b10
    } state_e;

    state_e                      state_q;
    logic [CntW-1:0]             cnt_q;
    logic [7:0]                  lat_q;
    logic                        pend_q;   // vld seen last cycle without a handshake
    logic                        done_q;
    logic                        err_q;
    logic [TopCount-1:0][63:0]   lane_q;

    logic hs;
    logic stall;
    logic ovf_err;
    logic ret_err;
    int   lane_idx;

`ifdef ROM_CTRL_KMAC_RESP_STALL_EN
    logic stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= hs;
        end
    end

    assign stall = stall_q;
`else
    assign stall = 1'b0;
`endif

    // Reset gates rdy directly: the state register already sits in Absorb
    // while reset is held, but nothing may be accepted until it is released.
    assign rom_rdy_o = rst_ni && (state_q == StAbsorb) && !stall;
    assign hs        = rom_vld_i && rom_rdy_o;

    always_comb begin
        lane_idx = int'(cnt_q) % TopCount;
    end

    assign ovf_err = hs && !rom_last_i && (cnt_q == CntW'(MaxWords - 1));
    // Only a pending word in Absorb counts; vld activity after the last word
    // is outside the message.
    assign ret_err = (state_q == StAbsorb) && pend_q && !rom_vld_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StAbsorb;
            cnt_q   <= '0;
            lat_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lane_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            pend_q <= rom_vld_i && !hs;
            case (state_q)
                StAbsorb: begin
                    if (ovf_err || ret_err) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        lane_q  <= '0;
                        state_q <= StDone;
                    end else if (hs) begin
                        for (int i = 0; i < TopCount; i++) begin
                            if (i == lane_idx) begin
                                lane_q[i] <= {lane_q[i][62:0], lane_q[i][63]} ^ rom_data_i;
                            end
                        end
                        if (cnt_q != CntW'(MaxWords)) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (rom_last_i) begin
                            // done_o is registered, so the pulse is set one
                            // cycle before it shows; latency 1 skips Squeeze.
                            if (DigestLatency <= 1) begin
                                done_q  <= 1'b1;
                                state_q <= StDone;
                            end else begin
                                lat_q   <= 8'(DigestLatency - 1);
                                state_q <= StSqueeze;
                            end
                        end
                    end
                end
                StSqueeze: begin
                    if (lat_q <= 8'd1) begin
                        done_q  <= 1'b1;
                        lat_q   <= '0;
                        state_q <= StDone;
                    end else begin
                        lat_q <= lat_q - 8'd1;
                    end
                end
                StDone: begin
                end
                default: begin
                    done_q  <= 1'b1;
                    err_q   <= 1'b1;
                    lane_q  <= '0;
                    state_q <= StDone;
                end
            endcase
        end
    end

    assign done_o   = done_q;
    assign err_o    = err_q;
    assign digest_o = lane_q;

endmodule

// File: tb/tb_rom_ctrl_kmac_resp.sv
module tb_rom_ctrl_kmac_resp;

`ifdef ROM_CTRL_KMAC_RESP_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vld = 1'b0;
    logic          last = 1'b0;
    logic [63:0]   data = '0;
    logic          rdy;
    logic          done;
    logic          err;
    logic [127:0]  digest;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rom_ctrl_kmac_resp #(
        .TopCount(2),
        .MaxWords(8),
        .DigestLatency(4)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .rom_vld_i (vld),
        .rom_last_i(last),
        .rom_data_i(data),
        .rom_rdy_o (rdy),
        .done_o    (done),
        .digest_o  (digest),
        .err_o     (err)
    );

    typedef struct {
        bit          vld;
        bit          last;
        logic [63:0] data;
        bit          rdy;
        bit          done;
        bit          err;
        logic [63:0] l0;
        logic [63:0] l1;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vld   = 1'b0;
        last  = 1'b0;
        data  = '0;
        step();
        chk("rst_rdy", 64'(rdy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_digest_lo", digest[63:0], 64'd0);
        chk("rst_digest_hi", digest[127:64], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Entered at negedge+1; returns at negedge+1 of the cycle after the handshake.
    task automatic send(input logic [63:0] d, input bit l);
        int n;
        n    = 0;
        vld  = 1'b1;
        data = d;
        last = l;
        while (!rdy && n < 5) begin
            step();
            n++;
        end
        if (!rdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: rdy stayed 0 for data %0h", d);
        end
        @(negedge clk);
        vld  = 1'b0;
        last = 1'b0;
        #1;
    endtask

    initial begin
        bit prev_hs;
        bit exp_rdy;

        // Gapped words 1,2,4 (last on 4): lane0 = rotl(1)^4 = 6, lane1 = 2.
        tbl[0] = '{1, 0, 64'h1, 1, 0, 0, 64'h0, 64'h0};
        tbl[1] = '{0, 0, 64'h0, 1, 0, 0, 64'h1, 64'h0};
        tbl[2] = '{1, 0, 64'h2, 1, 0, 0, 64'h1, 64'h0};
        tbl[3] = '{0, 0, 64'h0, 1, 0, 0, 64'h1, 64'h2};
        tbl[4] = '{1, 1, 64'h4, 1, 0, 0, 64'h1, 64'h2};
        tbl[5] = '{0, 0, 64'h0, 0, 0, 0, 64'h6, 64'h2};
        tbl[6] = '{0, 0, 64'h0, 0, 0, 0, 64'h6, 64'h2};
        tbl[7] = '{0, 0, 64'h0, 0, 0, 0, 64'h6, 64'h2};
        tbl[8] = '{0, 0, 64'h0, 0, 1, 0, 64'h6, 64'h2};
        tbl[9] = '{0, 0, 64'h0, 0, 0, 0, 64'h6, 64'h2};

        do_reset();

        prev_hs = 1'b0;
        for (int r = 0; r < 10; r++) begin
            step();
            vld  = tbl[r].vld;
            last = tbl[r].last;
            data = tbl[r].data;
            exp_rdy = tbl[r].rdy && !(STALL && prev_hs);
            chk($sformatf("tbl%0d_rdy", r), 64'(rdy), 64'(exp_rdy));
            chk($sformatf("tbl%0d_done", r), 64'(done), 64'(tbl[r].done));
            chk($sformatf("tbl%0d_err", r), 64'(err), 64'(tbl[r].err));
            chk($sformatf("tbl%0d_lane0", r), digest[63:0], tbl[r].l0);
            chk($sformatf("tbl%0d_lane1", r), digest[127:64], tbl[r].l1);
            prev_hs = tbl[r].vld && exp_rdy;
        end

        // Done is terminal: inputs ignored, digest held.
        for (int i = 0; i < 10; i++) begin
            step();
            vld  = 1'b1;
            data = 64'hFF;
            last = i[0];
            chk("done_hold_rdy", 64'(rdy), 64'd0);
            chk("done_hold_done", 64'(done), 64'd0);
            chk("done_hold_lane0", digest[63:0], 64'h6);
            chk("done_hold_lane1", digest[127:64], 64'h2);
        end
        vld  = 1'b0;
        last = 1'b0;

        // Reset two cycles after a last word discards it; fresh message 0x5.
        do_reset();
        send(64'h9, 1'b1);                       // t+1
        chk("r32_t1_done", 64'(done), 64'd0);
        step();                                  // t+2
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r32_rst_done", 64'(done), 64'd0);
            chk("r32_rst_digest", digest[63:0], 64'd0);
            chk("r32_rst_rdy", 64'(rdy), 64'd0);
        end
        rst_n = 1'b1;
        step();
        chk("r32_idle_done", 64'(done), 64'd0);
        send(64'h5, 1'b1);                       // t'+1
        for (int i = 1; i < 4; i++) begin
            chk("r32_wait_done", 64'(done), 64'd0);
            step();
        end
        chk("r32_done", 64'(done), 64'd1);
        chk("r32_err", 64'(err), 64'd0);
        chk("r32_lane0", digest[63:0], 64'h5);
        chk("r32_lane1", digest[127:64], 64'h0);
        step();
        chk("r32_done_pulse", 64'(done), 64'd0);

        // Overflow: 8 words without last with MaxWords=8.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send(64'(i + 1), 1'b0);
            chk("ovf_pre_done", 64'(done), 64'd0);
        end
        send(64'h8, 1'b0);
        chk("ovf_done", 64'(done), 64'd1);
        chk("ovf_err", 64'(err), 64'd1);
        chk("ovf_digest_lo", digest[63:0], 64'd0);
        chk("ovf_digest_hi", digest[127:64], 64'd0);
        chk("ovf_rdy", 64'(rdy), 64'd0);
        step();
        chk("ovf_done_pulse", 64'(done), 64'd0);
        chk("ovf_rdy_after", 64'(rdy), 64'd0);

`ifndef ROM_CTRL_KMAC_RESP_STALL_EN
        // Back-to-back words 1,2,4, last on 4 at cycle t.
        begin
            logic [63:0] w[3];
            w[0] = 64'h1;
            w[1] = 64'h2;
            w[2] = 64'h4;
            do_reset();
            vld = 1'b1;
            for (int k = 0; k < 3; k++) begin
                data = w[k];
                last = (k == 2);
                chk("b2b_rdy", 64'(rdy), 64'd1);
                step();
            end
            vld  = 1'b0;
            last = 1'b0;
            for (int i = 1; i < 4; i++) begin
                chk("b2b_wait_done", 64'(done), 64'd0);
                step();
            end
            chk("b2b_done", 64'(done), 64'd1);
            chk("b2b_err", 64'(err), 64'd0);
            chk("b2b_lane0", digest[63:0], 64'h6);
            chk("b2b_lane1", digest[127:64], 64'h2);
        end
`else
        // vld held high: rdy alternates, 4 handshakes in 7 cycles.
        begin
            logic [63:0] w[4];
            bit          pat[7];
            int          k;
            int          nhs;
            w[0] = 64'h1;
            w[1] = 64'h2;
            w[2] = 64'h4;
            w[3] = 64'h8;
            pat  = '{1, 0, 1, 0, 1, 0, 1};
            do_reset();
            k   = 0;
            nhs = 0;
            vld = 1'b1;
            for (int c = 0; c < 7; c++) begin
                data = w[k];
                last = (k == 3);
                chk($sformatf("stall_rdy%0d", c), 64'(rdy), 64'(pat[c]));
                if (rdy) nhs++;
                if (pat[c] && k < 3) k++;
                step();
            end
            vld  = 1'b0;
            last = 1'b0;
            chk("stall_hs_count", 64'(nhs), 64'd4);
            for (int i = 1; i < 4; i++) begin
                chk("stall_wait_done", 64'(done), 64'd0);
                step();
            end
            chk("stall_done", 64'(done), 64'd1);
            chk("stall_err", 64'(err), 64'd0);
            chk("stall_lane0", digest[63:0], 64'h6);
            chk("stall_lane1", digest[127:64], 64'hC);
        end

        // Retraction during the stall cycle.
        do_reset();
        vld  = 1'b1;
        data = 64'h1;
        chk("ret_rdy0", 64'(rdy), 64'd1);
        step();
        chk("ret_rdy1", 64'(rdy), 64'd0);
        step();
        vld = 1'b0;
        chk("ret_pre_done", 64'(done), 64'd0);
        step();
        chk("ret_done", 64'(done), 64'd1);
        chk("ret_err", 64'(err), 64'd1);
        chk("ret_digest", digest[63:0], 64'd0);
        chk("ret_rdy_after", 64'(rdy), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
